// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-15 pattern generator and detector.
package prbs_pkg;

    // Generator phases; the detector tracks the same phase names.
    typedef enum logic [1:0] {
        IDLE,
        SEND_PATTERN,
        SEND_PRBS,
        DONE
    } prbs_state_e;

    // PRBS-15 polynomial x^15 + x^14 + 1, expressed as register tap positions.
    localparam int PRBS_LEN   = 15;
    localparam int PRBS_TAP_A = 14;
    localparam int PRBS_TAP_B = 13;

    localparam logic [PRBS_LEN-1:0] DEFAULT_SEED = 15'h7FFF;

    localparam int BYTE_W = 8;

    // Advance a Fibonacci PRBS-15 register by one full byte (8 shifts).
    function automatic logic [PRBS_LEN-1:0] prbs15_adv8(input logic [PRBS_LEN-1:0] s);
        logic [PRBS_LEN-1:0] t;
        t = s;
        for (int i = 0; i < BYTE_W; i++) begin
            t = {t[PRBS_LEN-2:0], t[PRBS_TAP_A] ^ t[PRBS_TAP_B]};
        end
        return t;
    endfunction

    // Select byte idx of a 32-bit word, byte 0 being the least significant.
    function automatic logic [BYTE_W-1:0] pattern_byte(input logic [31:0] pat,
                                                       input logic [1:0]  idx);
        logic [BYTE_W-1:0] b;
        case (idx)
            2'd0:    b = pat[7:0];
            2'd1:    b = pat[15:8];
            2'd2:    b = pat[23:16];
            default: b = pat[31:24];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/prbs15_lfsr.sv
// PRBS-15 register with seed load and whole-byte advance.
// Asserting load and adv8 together yields the seed already advanced by one byte.
module prbs15_lfsr
    import prbs_pkg::*;
#(
    parameter logic [PRBS_LEN-1:0] SEED = DEFAULT_SEED
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                load,
    input  logic                adv8,
    output logic [PRBS_LEN-1:0] state
);

    logic [PRBS_LEN-1:0] base;
    logic [PRBS_LEN-1:0] state_nxt;

    // Next register value: optional reseed, then optional byte advance.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
        base      = state;
        state_nxt = state;
        if (load) base = SEED;
        state_nxt = adv8 ? prbs15_adv8(base) : base;
    end

    // Register update; reset returns to the seed so the sequence never sits at zero.
    always_ff @(posedge CLK or negedge RST) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!RST) state <= SEED;
        else      state <= state_nxt;
    end

endmodule

// File: rtl/prbs_pattern_gen.sv
// Byte-stream source: n_pattern copies of a 32-bit sync word (low byte first),
// then PRBS_BYTES bytes of PRBS-15 payload, then a one-cycle done pulse.
// OUT always holds the byte named by state/idx/cnt; each edge loads the following one.
module prbs_pattern_gen
    import prbs_pkg::*;
#(
    parameter logic [PRBS_LEN-1:0] SEED       = DEFAULT_SEED,
    parameter int                  PRBS_BYTES = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [31:0]       pattern,
    input  logic [7:0]        n_pattern,
    output logic [BYTE_W-1:0] OUT,
    output logic              out_valid,
    output logic              busy,
    output logic              done
);

    localparam logic [15:0] PRBS_LAST = 16'(PRBS_BYTES);

    prbs_state_e         state;
    logic [31:0]         pat_r;
    logic [7:0]          rep_r;
    logic [1:0]          idx;
    logic [15:0]         cnt;
    logic [PRBS_LEN-1:0] lfsr_q;
    logic                lfsr_load;
    logic                lfsr_adv8;

    // Only the low byte of the register is emitted; the rest feeds back internally.
    logic lfsr_unused;
    assign lfsr_unused = ^lfsr_q[PRBS_LEN-1:BYTE_W];

    prbs15_lfsr #(
        .SEED (SEED)
    ) u_lfsr (
        .CLK   (CLK),
        .RST   (RST),
        .load  (lfsr_load),
        .adv8  (lfsr_adv8),
        .state (lfsr_q)
    );

    // LFSR control: reseed on accepted start, advance whenever a PRBS byte is loaded into OUT.
    always_comb begin
        lfsr_load = 1'b0;
        lfsr_adv8 = 1'b0;
        case (state)
            IDLE: begin
                lfsr_load = start;
                lfsr_adv8 = start && (n_pattern == 8'd0);
            end
            SEND_PATTERN: lfsr_adv8 = (idx == 2'd3) && (rep_r == 8'd1);
            SEND_PRBS:    lfsr_adv8 = (cnt != PRBS_LAST);
            default:      lfsr_adv8 = 1'b0;
        endcase
    end

    // Sequencer FSM with registered stream outputs.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state     <= IDLE;
            pat_r     <= '0;
            rep_r     <= '0;
            idx       <= '0;
            cnt       <= '0;
            OUT       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    OUT       <= '0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        pat_r     <= pattern;
                        rep_r     <= n_pattern;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        if (n_pattern != 8'd0) begin
                            state <= SEND_PATTERN;
                            idx   <= 2'd0;
                            OUT   <= pattern[7:0];
                        end else begin
                            state <= SEND_PRBS;
                            cnt   <= 16'd1;
                            OUT   <= SEED[BYTE_W-1:0];
                        end
                    end
                end
                SEND_PATTERN: begin
                    if (idx == 2'd3) begin
                        rep_r <= rep_r - 8'd1;
                        if (rep_r == 8'd1) begin
                            state <= SEND_PRBS;
                            cnt   <= 16'd1;
                            OUT   <= lfsr_q[BYTE_W-1:0];
                        end else begin
                            idx <= 2'd0;
                            OUT <= pat_r[7:0];
                        end
                    end else begin
                        idx <= idx + 2'd1;
                        OUT <= pattern_byte(pat_r, idx + 2'd1);
                    end
                end
                SEND_PRBS: begin
                    if (cnt == PRBS_LAST) begin
                        state     <= DONE;
                        cnt       <= '0;
                        OUT       <= '0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                        OUT <= lfsr_q[BYTE_W-1:0];
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prbs_pattern_gen.sv
// Self-checking bench for prbs_pattern_gen: table-driven runs, random runs,
// back-to-back runs with start held high, and reset during the payload.
module tb_prbs_pattern_gen;

    localparam int          PRBS_BYTES = 16;
    localparam logic [14:0] SEED       = 15'h7FFF;

    logic        CLK;
    logic        RST;
    logic        start;
    logic [31:0] pattern;
    logic [7:0]  n_pattern;
    logic [7:0]  OUT;
    logic        out_valid;
    logic        busy;
    logic        done;

    int n_checks;
    int n_errors;

    logic [7:0] exp_q[$];

    prbs_pattern_gen #(
        .SEED       (SEED),
        .PRBS_BYTES (PRBS_BYTES)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .start     (start),
        .pattern   (pattern),
        .n_pattern (n_pattern),
        .OUT       (OUT),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference stream: pattern bytes by shifting the word, payload from the
    // PRBS-15 bit recurrence x[n] = x[n-15] ^ x[n-14] over a flat bit array.
    task automatic build_expected(input logic [31:0] pat, input logic [7:0] n);
        bit x[];
        int nbits;
        exp_q.delete();
        for (int r = 0; r < int'(n); r++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'((pat >> (8 * b)) & 32'hFF));
        nbits = 15 + 8 * PRBS_BYTES;
        x = new[nbits];
        for (int i = 0; i < 15; i++) x[i] = SEED[14 - i];
        for (int i = 15; i < nbits; i++) x[i] = x[i - 15] ^ x[i - 14];
        for (int k = 0; k < PRBS_BYTES; k++) begin
            logic [7:0] byte_v;
            for (int j = 0; j < 8; j++) byte_v[j] = x[14 + 8 * k - j];
            exp_q.push_back(byte_v);
        end
    endtask

    // Called at the negedge right after the accepting edge. Checks every
    // stream byte, the DONE cycle and the following IDLE cycle.
    // Drives pattern to mid_pat partway through to prove it is not re-read.
    task automatic check_stream(input logic [31:0] pat, input logic [7:0] n,
                                input logic [31:0] mid_pat, input string tag,
                                output int nvalid, output logic [7:0] first_b);
        build_expected(pat, n);
        nvalid  = 0;
        first_b = OUT;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (out_valid === 1'b1) nvalid++;
            check($sformatf("%s byte%0d OUT", tag, i), 32'(OUT), 32'(exp_q[i]));
            check($sformatf("%s byte%0d valid", tag, i), 32'(out_valid), 32'd1);
            check($sformatf("%s byte%0d busy", tag, i), 32'(busy), 32'd1);
            check($sformatf("%s byte%0d done", tag, i), 32'(done), 32'd0);
            if (i == 2) pattern = mid_pat;
            @(negedge CLK);
        end
        check($sformatf("%s done pulse", tag), 32'(done), 32'd1);
        check($sformatf("%s done-cycle valid", tag), 32'(out_valid), 32'd0);
        check($sformatf("%s done-cycle busy", tag), 32'(busy), 32'd1);
        check($sformatf("%s done-cycle OUT", tag), 32'(OUT), 32'd0);
        @(negedge CLK);
        check($sformatf("%s idle done", tag), 32'(done), 32'd0);
        check($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
        check($sformatf("%s idle valid", tag), 32'(out_valid), 32'd0);
    endtask

    // Present a one-cycle start and return at the negedge after acceptance.
    task automatic pulse_start(input logic [31:0] pat, input logic [7:0] n);
        start     = 1'b1;
        pattern   = pat;
        n_pattern = n;
        @(negedge CLK);
        start = 1'b0;
    endtask

    typedef struct {
        logic [31:0] pat;
        logic [7:0]  n;
        logic [7:0]  first_b;
        int          len;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int          nv;
        logic [7:0]  fb;
        logic [31:0] rp;
        logic [7:0]  rn;

        n_checks  = 0;
        n_errors  = 0;
        start     = 1'b0;
        pattern   = '0;
        n_pattern = '0;

        vecs[0] = '{pat: 32'hDEADBEEF, n: 8'd2,   first_b: 8'hEF, len: 24};
        vecs[1] = '{pat: 32'hCAFEF00D, n: 8'd0,   first_b: 8'hFF, len: 16};
        vecs[2] = '{pat: 32'h12345678, n: 8'd1,   first_b: 8'h78, len: 20};
        vecs[3] = '{pat: 32'h01020304, n: 8'd255, first_b: 8'h04, len: 1036};

        // Reset state.
        RST = 1'b0;
        #1;
        check("reset OUT", 32'(OUT), 32'd0);
        check("reset valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("post-reset idle valid", 32'(out_valid), 32'd0);

        // Table-driven runs.
        for (int v = 0; v < 4; v++) begin
            pulse_start(vecs[v].pat, vecs[v].n);
            check_stream(vecs[v].pat, vecs[v].n, 32'hFFFF0000, $sformatf("vec%0d", v), nv, fb);
            check($sformatf("vec%0d length", v), 32'(nv), 32'(vecs[v].len));
            check($sformatf("vec%0d first byte", v), 32'(fb), 32'(vecs[v].first_b));
            @(negedge CLK);
        end

        // Hand-checked payload start: FF then 00 for the default seed.
        pulse_start(32'h0, 8'd0);
        check("seed byte0", 32'(OUT), 32'hFF);
        @(negedge CLK);
        check("seed byte1", 32'(OUT), 32'h00);
        repeat (PRBS_BYTES + 2) @(negedge CLK);
        check("seed run idle", 32'(busy), 32'd0);

        // Randomized runs against the model.
        for (int r = 0; r < 6; r++) begin
            rp = $urandom;
            rn = 8'($urandom_range(0, 6));
            pulse_start(rp, rn);
            check_stream(rp, rn, ~rp, $sformatf("rnd%0d", r), nv, fb);
            check($sformatf("rnd%0d length", r), 32'(nv), 32'(4 * int'(rn) + PRBS_BYTES));
        end

        // Start held high across two runs; pattern changed mid-run.
        start     = 1'b1;
        pattern   = 32'hA1B2C3D4;
        n_pattern = 8'd2;
        @(negedge CLK);
        check_stream(32'hA1B2C3D4, 8'd2, 32'h55667788, "hold run1", nv, fb);
        // start still high during this IDLE cycle: the next edge must accept.
        @(negedge CLK);
        start = 1'b0;
        check_stream(32'h55667788, 8'd2, 32'h55667788, "hold run2", nv, fb);
        @(negedge CLK);
        check("hold no third run", 32'(out_valid), 32'd0);

        // Reset during the PRBS phase.
        pulse_start(32'h11223344, 8'd1);
        repeat (7) @(negedge CLK);
        check("pre-reset valid", 32'(out_valid), 32'd1);
        RST = 1'b0;
        #1;
        check("midrst OUT", 32'(OUT), 32'd0);
        check("midrst valid", 32'(out_valid), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check($sformatf("after-reset quiet%0d valid", i), 32'(out_valid), 32'd0);
            check($sformatf("after-reset quiet%0d busy", i), 32'(busy), 32'd0);
        end
        pulse_start(32'h11223344, 8'd1);
        check_stream(32'h11223344, 8'd1, 32'h11223344, "post-reset run", nv, fb);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/prbs_pattern_gen.md
# prbs_pattern_gen

Byte-stream source that feeds the PRBS pattern detector. On `start` it emits a 32-bit sync pattern, one byte per clock and low byte first, repeated `n_pattern` times. It then emits a PRBS-15 payload of `PRBS_BYTES` bytes and signals completion. Byte order and repetition semantics match what the detector consumes on its `IN` / `n_pattern` inputs.

## Interface
- `SEED`, default 15'h7FFF: PRBS-15 LFSR seed, reloaded at every start; must be non-zero.
- `PRBS_BYTES`, default 16: number of PRBS bytes emitted after the pattern phase; range 1..65535.
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: reset, asynchronous, active-low.
- `start`  in  1: run request; sampled only in IDLE.
- `pattern`  in  32: sync pattern; captured on accepted start.
- `n_pattern`  in  8: pattern repetitions, 0..255; captured on accepted start.
- `OUT`  out  8: output byte, registered.
- `out_valid`  out  1: `OUT` holds a stream byte this cycle.
- `busy`  out  1: high from accepted start through the DONE cycle.
- `done`  out  1: one-cycle pulse after the last byte.

## Operation
- Reset (async, immediate, also mid-run): state IDLE, `OUT`=0, `out_valid`=0, `busy`=0, `done`=0, LFSR=`SEED`, counters=0.
- FSM states:
  - IDLE:
    - Outputs low, `OUT`=0.
    - `start`=1 captures `pattern` into `pat_r` and `n_pattern` into `rep_r`, and loads LFSR=`SEED`.
    - If `n_pattern`≠0, go to SEND_PATTERN with byte index 0; otherwise go to SEND_PRBS.
  - SEND_PATTERN:
    - Emits `pat_r[8*idx+7 -: 8]`, idx 0→3, and wraps to 0.
    - On idx=3, decrements `rep_r`.
    - When idx=3 and `rep_r`=1, go to SEND_PRBS.
  - SEND_PRBS:
    - Emits LFSR[7:0], then advances the LFSR 8 steps.
    - The 16-bit byte counter counts to `PRBS_BYTES`; on the last byte, go to DONE.
  - DONE: `done`=1, `out_valid`=0, `busy`=1, then unconditionally go to IDLE.
- LFSR step (Fibonacci, x^15+x^14+1): `nb = s[14]^s[13]`, `s <= {s[13:0], nb}`. A byte advance is 8 steps in one cycle (combinational unroll).
- `start` while not in IDLE is ignored; input changes after capture have no effect.
- Stream length = 4·`n_pattern` + `PRBS_BYTES` valid cycles, contiguous, with no gaps.

## Timing
- `start` sampled high at edge k: the first byte appears on `OUT` with `out_valid`=1 after edge k, so latency is 1 cycle. `busy` rises at the same edge.
- Bytes change on every rising edge while `out_valid`=1.
- `done` is high in the cycle immediately after the last valid byte. `busy` falls at the next edge.
- Earliest re-accept: `start` high in the first IDLE cycle after DONE. The minimum gap between streams is 2 cycles with `out_valid`=0: DONE plus IDLE.
- `n_pattern`=255 gives 1020 pattern bytes; `rep_r` is 8 bits with no overflow.
- The LFSR never reaches zero given a non-zero `SEED`.

## Structure
- Shared package `prbs_pkg`, used by the generator and the detector:
  - state enum typedef: IDLE, SEND_PATTERN, SEND_PRBS, DONE;
  - PRBS-15 tap constants;
  - default seed;
  - byte width constant.
- One sub-module, `prbs15_lfsr`:
  - 15-bit register with `load` (seed) and `adv8` controls;
  - async active-low reset to `SEED`;
  - outputs the current state.
- The top level holds the FSM, `pat_r`, `rep_r`, byte index, byte counter and the output registers.

## Test plan
- Basic run: `pattern`=32'hDEADBEEF, `n_pattern`=2, default parameters, one-cycle `start`.
  - Required `OUT`: EF BE AD DE EF BE AD DE FF 00 …, 24 valid bytes in total.
  - `done` pulses the cycle after byte 24; `busy` covers 25 cycles.
- Zero repetitions: `n_pattern`=0.
  - The first byte, one cycle after `start`, is 8'hFF, followed by 8'h00.
  - 16 valid bytes, then `done`.
- Start while busy: hold `start`=1 through the whole run, with `pattern` changed mid-run.
  - The stream is unchanged.
  - The second run starts exactly 2 cycles after the last byte.
  - The second run's PRBS bytes equal the first run's.
- Reset mid-run: drop `RST` during the PRBS phase.
  - All outputs read 0 before the next clock edge.
  - After release, no output until a new `start`.
- Maximum repetitions: `n_pattern`=255, `pattern`=32'h01020304.
  - 1020 pattern bytes, cycling 04 03 02 01, then 16 PRBS bytes.
- Loopback with the detector: connect `OUT` to the detector's `IN` and the same `n_pattern`=3.
  - The detector's `Pattern_Found` asserts; the generator's `done` is observed.
